// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO register pair.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU starts are ignored.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept;
    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] acc_step;
    logic [63:0] prod;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [64:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [31:0] quot, rem;
`endif

    always_comb begin
        is_signed = ~op[0];
        a_mag     = (is_signed && a[31]) ? -a : a;
        b_mag     = (is_signed && b[31]) ? -b : b;
`ifdef MULDIV_DIV_EN
        accept    = start && !cancel && (state_q == StIdle);
`else
        accept    = start && !cancel && (state_q == StIdle) && !op[1];
`endif
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        acc_step = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q, 1'b0};
        div_diff  = div_shift[63:32] - opnd_q;
        div_ge    = div_shift[64:32] >= {1'b0, opnd_q};
        if (is_div_q) begin
            acc_step = {(div_ge ? div_diff : div_shift[63:32]), acc_q[30:0], div_ge};
        end
        quot = neg_q ? -acc_step[31:0] : acc_step[31:0];
        rem  = neg_rem_q ? -acc_step[63:32] : acc_step[63:32];
`endif
        prod = neg_q ? -acc_step : acc_step;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (we_hi) hi_d = wd;
                if (we_lo) lo_d = wd;
                if (accept) begin
                    state_d = StRun;
                    cnt_d   = 5'd0;
                    neg_d   = is_signed & (a[31] ^ b[31]);
                    acc_d   = {32'd0, b_mag};
                    opnd_d  = a_mag;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op[1];
                    neg_rem_d = is_signed & a[31];
                    dz_d      = (b == 32'd0);
                    if (op[1]) begin
                        acc_d  = {32'd0, a_mag};
                        opnd_d = b_mag;
                    end
`endif
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                        if (is_div_q) begin
                            lo_d = dz_q ? 32'hFFFF_FFFF : quot;
                            hi_d = rem;
                        end else begin
                            hi_d = prod[63:32];
                            lo_d = prod[31:0];
                        end
`else
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            neg_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == StRun);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo}, a monitor checks on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int dc_snap;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .we_hi  (we_hi),
        .we_lo  (we_lo),
        .wd     (wd),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        total_cnt++;
        if (got === expv) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, expv);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected done", 64'(done), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result hi/lo", {hi, lo}, mon_exp);
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [63:0] e, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input string name, input int exp_busy);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("%s busy cycles", name), 64'(n), 64'(exp_busy));
        check($sformatf("%s done pulse", name), 64'(done), 64'd1);
        @(negedge clk);
        check($sformatf("%s done low", name), 64'(done), 64'd0);
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [63:0] e);
        launch(o, ia, ib, e, 1'b1);
        finish_op(name, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run("multu_shift", OpMultu, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);
        run("mult_minmin", OpMult, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run("mult_negneg", OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'h0000_0000_0000_0002);
        run("multu_x2", OpMultu, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        run("mult_x2", OpMult, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);

        // Start and MTHI on the same edge: write lands now, result overwrites later.
        @(negedge clk);
        start = 1'b1; op = OpMultu; a = 32'd2; b = 32'd3; we_hi = 1'b1; wd = 32'hDEAD;
        exp_q.push_back(64'h0000_0000_0000_0006);
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0;
        check("coincident mthi", 64'(hi), 64'hDEAD);
        finish_op("coincident op", 32);

        // Second start and MTHI while busy are ignored.
        launch(OpMultu, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        @(negedge clk);
        start = 1'b1; op = OpMultu; a = 32'd9; b = 32'd9; we_hi = 1'b1; wd = 32'h1234;
        @(negedge clk);
        start = 1'b0; we_hi = 1'b0;
        check("busy mthi ignored", 64'(hi), 64'd0);
        finish_op("busy ignore", 30);

        // Cancel at RUN cycle 10 after MTLO.
        @(negedge clk);
        we_lo = 1'b1; wd = 32'hAA;
        @(negedge clk);
        we_lo = 1'b0;
        check("mtlo idle", 64'(lo), 64'hAA);
        dc_snap = done_cnt;
        launch(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy low", 64'(busy), 64'd0);
        check("cancel hi/lo kept", {hi, lo}, 64'h0000_0000_0000_00AA);
        repeat (40) @(negedge clk);
        check("cancel no done", 64'(done_cnt), 64'(dc_snap));

        // Cancel together with start in IDLE drops the start.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OpMultu; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel+start busy", 64'(busy), 64'd0);
        repeat (36) @(negedge clk);
        check("cancel+start lo kept", 64'(lo), 64'hAA);

        // Cancel on the completing edge suppresses update and done.
        dc_snap = done_cnt;
        launch(OpMultu, 32'd5, 32'd5, 64'd0, 1'b0);
        repeat (31) @(negedge clk);
        check("last run cycle busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("late cancel busy/done", {62'd0, busy, done}, 64'd0);
        check("late cancel hi/lo kept", {hi, lo}, 64'h0000_0000_0000_00AA);
        repeat (3) @(negedge clk);
        check("late cancel no done", 64'(done_cnt), 64'(dc_snap));

`ifdef MULDIV_DIV_EN
        run("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu_zero", OpDivu, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        run("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("divu_100_7", OpDivu, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        run("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run("div_m5_zero", OpDiv, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
`else
        dc_snap = done_cnt;
        launch(OpDiv, 32'd100, 32'd7, 64'd0, 1'b0);
        check("no-div busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("no-div no done", 64'(done_cnt), 64'(dc_snap));
        check("no-div hi/lo kept", {hi, lo}, 64'h0000_0000_0000_00AA);
`endif

        // Reset mid-operation clears everything at once and leaves no done behind.
        run("pre-reset", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        launch(OpMultu, 32'd7, 32'd9, 64'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset hi/lo", {hi, lo}, 64'd0);
        check("async reset busy/done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc_snap = done_cnt;
        repeat (40) @(negedge clk);
        check("post-reset no done", 64'(done_cnt), 64'(dc_snap));
        check("post-reset idle", 64'(busy), 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
